// File: rtl/clk_set_pkg.sv
// Shared types and constants for the time-setting controller.
// State encoding, field limits, per-field blink masks and the
// wrap-around step helpers used by the field arithmetic.
package clk_set_pkg;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      SET_HOUR = 3'd1,
      SET_MIN  = 3'd2,
      SET_SEC  = 3'd3,
      COMMIT   = 3'd4
   } state_t;

   localparam logic [4:0] HOUR_MAX = 5'd23;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [5:0] SEC_MAX  = 6'd59;

   // Digit layout HH-MM-SS, bit 7 is the leftmost digit.
   localparam logic [7:0] MASK_HOUR = 8'b1100_0000;
   localparam logic [7:0] MASK_MIN  = 8'b0001_1000;
   localparam logic [7:0] MASK_SEC  = 8'b0000_0011;
   localparam logic [7:0] MASK_NONE = 8'b0000_0000;

   // Hour step with wrap: 23 -> 0 going up, 0 -> 23 going down.
   function automatic logic [4:0] step_hour(input logic [4:0] val, input logic up);
      logic [4:0] res;
      if (up) begin
         res = (val >= HOUR_MAX) ? 5'd0 : val + 5'd1;
      end else begin
         res = (val == 5'd0) ? HOUR_MAX : val - 5'd1;
      end
      return res;
   endfunction

   // Minute/second step with wrap at the given maximum.
   function automatic logic [5:0] step_sixty(input logic [5:0] val, input logic [5:0] max,
                                             input logic up);
      logic [5:0] res;
      if (up) begin
         res = (val >= max) ? 6'd0 : val + 6'd1;
      end else begin
         res = (val == 6'd0) ? max : val - 6'd1;
      end
      return res;
   endfunction

   // True in the three states where a field is being edited.
   function automatic logic is_edit(input state_t st);
      return (st == SET_HOUR) || (st == SET_MIN) || (st == SET_SEC);
   endfunction

   // Digits that blank while the blink phase is in its dark half.
   function automatic logic [7:0] field_mask(input state_t st);
      logic [7:0] m;
      case (st)
         SET_HOUR: m = MASK_HOUR;
         SET_MIN:  m = MASK_MIN;
         SET_SEC:  m = MASK_SEC;
         default:  m = MASK_NONE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on the debounced rising edge. Latency from a
// clean raw edge to the press pulse is DEBOUNCE_CYC+3 cycles.
// With SET_TIME_AUTO_REPEAT_EN defined the debounced level is also
// exported so the controller can detect a held button.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 2_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
`ifdef SET_TIME_AUTO_REPEAT_EN
   output logic level,
`endif
   output logic press
);

   localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic          sync1;
   logic          sync2;
   logic          stable;
   logic          stable_d;
   logic [CW-1:0] cnt;

`ifdef SET_TIME_AUTO_REPEAT_EN
   assign level = stable;
`endif

   // Synchronize, accept a new level after DEBOUNCE_CYC differing samples, pulse on rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= {CW{1'b0}};
         press    <= 1'b0;
      end else begin
         sync1    <= btn;
         sync2    <= sync1;
         stable_d <= stable;
         press    <= stable & ~stable_d;
         if (sync2 == stable) begin
            cnt <= {CW{1'b0}};
         end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= {CW{1'b0}};
         end else begin
            cnt <= cnt + CW'(1'b1);
         end
      end
   end

endmodule

// File: rtl/set_time_ctrl.sv
// Time-setting controller: walks the user through hour, minute and
// second edit fields with mode/inc/dec buttons, keeps shadow values,
// drives the digit blink mask and strobes load to write the new time.
// Optional feature macro: SET_TIME_AUTO_REPEAT_EN (held inc/dec repeats).
module set_time_ctrl
   import clk_set_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC   = 2_000_000,
   parameter int unsigned BLINK_HALF_CYC = 25_000_000,
   parameter int unsigned TIMEOUT_CYC    = 1_000_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   output logic [4:0] set_hour,
   output logic [5:0] set_min,
   output logic [5:0] set_sec,
   output logic       load,
   output logic       editing,
   output logic [7:0] blink_mask
);

   localparam int unsigned BW = (BLINK_HALF_CYC > 1) ? $clog2(BLINK_HALF_CYC) : 1;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

   state_t        state;
   state_t        state_nx;
   logic [4:0]    hour_nx;
   logic [5:0]    min_nx;
   logic [5:0]    sec_nx;
   logic [TW-1:0] tmo_cnt;
   logic [TW-1:0] tmo_nx;
   logic [BW-1:0] blink_cnt;
   logic [BW-1:0] blink_nx;
   logic          phase;
   logic          phase_nx;
   logic          load_nx;
   logic          editing_nx;
   logic [7:0]    mask_nx;

   logic          mode_p;
   logic          inc_p;
   logic          dec_p;
   logic          inc_req;
   logic          dec_req;
   logic          inc_ev;
   logic          dec_ev;
   logic          any_evt;

`ifdef SET_TIME_AUTO_REPEAT_EN
   localparam int unsigned REPEAT_HOLD_CYC   = 50_000_000;
   localparam int unsigned REPEAT_PERIOD_CYC = 10_000_000;
   localparam int unsigned RW = $clog2(REPEAT_HOLD_CYC);
   localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_HOLD_CYC - 1);
   localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_HOLD_CYC - REPEAT_PERIOD_CYC);

   logic          inc_level;
   logic          dec_level;
   logic          inc_rep;
   logic          dec_rep;
   logic [RW-1:0] rep_cnt;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
      .clk(clk), .reset(reset), .btn(btn_mode), .level(), .press(mode_p));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc (
      .clk(clk), .reset(reset), .btn(btn_inc), .level(inc_level), .press(inc_p));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dec (
      .clk(clk), .reset(reset), .btn(btn_dec), .level(dec_level), .press(dec_p));

   // Time how long exactly one of inc/dec is held and emit periodic repeat events.
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_cnt <= {RW{1'b0}};
         inc_rep <= 1'b0;
         dec_rep <= 1'b0;
      end else begin
         inc_rep <= 1'b0;
         dec_rep <= 1'b0;
         if (inc_level ^ dec_level) begin
            if (rep_cnt == REP_LAST) begin
               rep_cnt <= REP_RELOAD;
               inc_rep <= inc_level;
               dec_rep <= dec_level;
            end else begin
               rep_cnt <= rep_cnt + RW'(1'b1);
            end
         end else begin
            rep_cnt <= {RW{1'b0}};
         end
      end
   end

   assign inc_req = inc_p | inc_rep;
   assign dec_req = dec_p | dec_rep;
`else
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
      .clk(clk), .reset(reset), .btn(btn_mode), .press(mode_p));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc (
      .clk(clk), .reset(reset), .btn(btn_inc), .press(inc_p));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dec (
      .clk(clk), .reset(reset), .btn(btn_dec), .press(dec_p));

   assign inc_req = inc_p;
   assign dec_req = dec_p;
`endif

   // Resolve simultaneous buttons: mode wins, inc together with dec cancels.
   always_comb begin
      inc_ev  = inc_req & ~dec_req & ~mode_p;
      dec_ev  = dec_req & ~inc_req & ~mode_p;
      any_evt = mode_p | inc_req | dec_req;
   end

   // Next state, shadow field arithmetic and idle timeout.
   always_comb begin
      state_nx = state;
      hour_nx  = set_hour;
      min_nx   = set_min;
      sec_nx   = set_sec;
      tmo_nx   = tmo_cnt;
      case (state)
         RUN: begin
            tmo_nx = {TW{1'b0}};
            if (mode_p) begin
               state_nx = SET_HOUR;
               hour_nx  = (cur_hour > HOUR_MAX) ? 5'd0 : cur_hour;
               min_nx   = (cur_min  > MIN_MAX)  ? 6'd0 : cur_min;
               sec_nx   = (cur_sec  > SEC_MAX)  ? 6'd0 : cur_sec;
            end else begin
               state_nx = RUN;
            end
         end
         SET_HOUR, SET_MIN, SET_SEC: begin
            if (any_evt) begin
               tmo_nx = {TW{1'b0}};
            end else begin
               tmo_nx = tmo_cnt + TW'(1'b1);
            end
            if (mode_p) begin
               case (state)
                  SET_HOUR: state_nx = SET_MIN;
                  SET_MIN:  state_nx = SET_SEC;
                  default:  state_nx = COMMIT;
               endcase
            end else if (!any_evt && (tmo_cnt == TMO_LAST)) begin
               // Abandon the edit: shadow values stay, no load.
               state_nx = RUN;
            end else if (inc_ev || dec_ev) begin
               case (state)
                  SET_HOUR: hour_nx = step_hour(set_hour, inc_ev);
                  SET_MIN:  min_nx  = step_sixty(set_min, MIN_MAX, inc_ev);
                  default:  sec_nx  = step_sixty(set_sec, SEC_MAX, inc_ev);
               endcase
            end else begin
               state_nx = state;
            end
         end
         COMMIT: begin
            state_nx = RUN;
            tmo_nx   = {TW{1'b0}};
         end
         default: begin
            state_nx = RUN;
            tmo_nx   = {TW{1'b0}};
         end
      endcase
   end

   // Blink phase: restarts visible on field entry or any change, then toggles.
   always_comb begin
      blink_nx = blink_cnt;
      phase_nx = phase;
      if (!is_edit(state_nx)) begin
         blink_nx = {BW{1'b0}};
         phase_nx = 1'b0;
      end else if ((state_nx != state) || inc_ev || dec_ev) begin
         blink_nx = {BW{1'b0}};
         phase_nx = 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_nx = {BW{1'b0}};
         phase_nx = ~phase;
      end else begin
         blink_nx = blink_cnt + BW'(1'b1);
      end
   end

   // Output values derived from the upcoming state so they register alongside it.
   always_comb begin
      load_nx    = (state_nx == COMMIT);
      editing_nx = is_edit(state_nx);
      if (phase_nx) begin
         mask_nx = field_mask(state_nx);
      end else begin
         mask_nx = MASK_NONE;
      end
   end

   // State, shadow fields, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         set_hour   <= 5'd0;
         set_min    <= 6'd0;
         set_sec    <= 6'd0;
         tmo_cnt    <= {TW{1'b0}};
         blink_cnt  <= {BW{1'b0}};
         phase      <= 1'b0;
         load       <= 1'b0;
         editing    <= 1'b0;
         blink_mask <= 8'h00;
      end else begin
         state      <= state_nx;
         set_hour   <= hour_nx;
         set_min    <= min_nx;
         set_sec    <= sec_nx;
         tmo_cnt    <= tmo_nx;
         blink_cnt  <= blink_nx;
         phase      <= phase_nx;
         load       <= load_nx;
         editing    <= editing_nx;
         blink_mask <= mask_nx;
      end
   end

endmodule

// File: tb/tb_set_time_ctrl.sv
// Self-checking bench for set_time_ctrl with short debounce, blink and
// timeout intervals. A field-level reference model predicts the shadow
// time; committed times go into a queue that a load monitor drains.
module tb_set_time_ctrl;

   localparam int D = 4;
   localparam int B = 8;
   localparam int T = 200;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_mode, btn_inc, btn_dec;
   logic [4:0] cur_hour;
   logic [5:0] cur_min, cur_sec;
   logic [4:0] set_hour;
   logic [5:0] set_min, set_sec;
   logic       load, editing;
   logic [7:0] blink_mask;

   int n_cmp = 0;
   int n_bad = 0;

   logic [16:0] exp_q[$];
   int m_state;        // 0 = running, 1/2/3 = editing hour/minute/second
   int m_h, m_m, m_s;

   set_time_ctrl #(.DEBOUNCE_CYC(D), .BLINK_HALF_CYC(B), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .reset(reset),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
      .load(load), .editing(editing), .blink_mask(blink_mask));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Load monitor: every load pulse must match the oldest predicted commit.
   always @(negedge clk) begin
      logic [16:0] e;
      if (reset === 1'b0 && load === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_load: got load=1 expected no load (time %0t)", $time);
         end else begin
            e = exp_q.pop_front();
            check("load_hour", set_hour, e[16:12]);
            check("load_min", set_min, e[11:6]);
            check("load_sec", set_sec, e[5:0]);
            check("load_editing", editing, 0);
         end
      end
   end

   // Reference model: effect of one debounced press set on the editing session.
   task automatic apply(input logic m, input logic i, input logic d);
      int delta;
      logic [16:0] e;
      if (m) begin
         if (m_state == 0) begin
            m_h = (cur_hour > 23) ? 0 : cur_hour;
            m_m = (cur_min > 59) ? 0 : cur_min;
            m_s = (cur_sec > 59) ? 0 : cur_sec;
            m_state = 1;
         end else if (m_state < 3) begin
            m_state++;
         end else begin
            e = {5'(m_h), 6'(m_m), 6'(m_s)};
            exp_q.push_back(e);
            m_state = 0;
         end
      end else if (m_state != 0 && (i ^ d)) begin
         delta = i ? 1 : -1;
         if (m_state == 1) m_h = (m_h + delta + 24) % 24;
         else if (m_state == 2) m_m = (m_m + delta + 60) % 60;
         else m_s = (m_s + delta + 60) % 60;
      end
   endtask

   // Clean press and release of the given buttons, held long enough to debounce.
   task automatic press(input logic m, input logic i, input logic d);
      apply(m, i, d);
      @(negedge clk);
      btn_mode = m; btn_inc = i; btn_dec = d;
      repeat (D + 8) @(negedge clk);
      btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
      repeat (D + 8) @(negedge clk);
   endtask

   task automatic check_fields(input string tag);
      check({tag, "_hour"}, set_hour, m_h);
      check({tag, "_min"}, set_min, m_m);
      check({tag, "_sec"}, set_sec, m_s);
      check({tag, "_editing"}, editing, (m_state != 0) ? 1 : 0);
      if (m_state == 0) check({tag, "_mask"}, blink_mask, 0);
   endtask

   task automatic go_run();
      while (m_state != 0) begin
         press(1'b1, 1'b0, 1'b0);
         check_fields("go_run");
      end
   endtask

   initial begin
      int r;
      int h0;
      logic [7:0] em;
      reset = 1'b1;
      btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
      cur_hour = 5'd0; cur_min = 6'd0; cur_sec = 6'd0;
      m_state = 0; m_h = 0; m_m = 0; m_s = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_load", load, 0);
      check_fields("rst");

      // Full edit: 12:34:56 -> 14:33:56.
      cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
      press(1'b1, 1'b0, 1'b0); check_fields("full_mode1");
      press(1'b0, 1'b1, 1'b0); check_fields("full_inc1");
      press(1'b0, 1'b1, 1'b0); check_fields("full_inc2");
      press(1'b1, 1'b0, 1'b0); check_fields("full_mode2");
      press(1'b0, 1'b0, 1'b1); check_fields("full_dec");
      press(1'b1, 1'b0, 1'b0); check_fields("full_mode3");
      press(1'b1, 1'b0, 1'b0); check_fields("full_commit");
      check("full_hour14", set_hour, 14);
      check("full_min33", set_min, 33);
      check("full_loaded", exp_q.size(), 0);

      // Wrap in every field.
      cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd0;
      press(1'b1, 1'b0, 1'b0); press(1'b0, 1'b1, 1'b0); check_fields("wrap_hour");
      check("wrap_hour0", set_hour, 0);
      press(1'b1, 1'b0, 1'b0); press(1'b0, 1'b1, 1'b0); check_fields("wrap_min");
      check("wrap_min0", set_min, 0);
      press(1'b1, 1'b0, 1'b0); press(1'b0, 1'b0, 1'b1); check_fields("wrap_sec");
      check("wrap_sec59", set_sec, 59);
      go_run();

      // Bounce: raw inc chatters, then settles high; one increment, D+3 to press, +1 to field.
      cur_hour = 5'd5; cur_min = 6'd10; cur_sec = 6'd20;
      press(1'b1, 1'b0, 1'b0); check_fields("bounce_entry");
      h0 = m_h;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (t % 2 == 0) btn_inc = ~btn_inc;
         check("bounce_chatter", set_hour, h0);
      end
      @(negedge clk);
      btn_inc = 1'b1;
      apply(1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check("bounce_latency", set_hour, (k >= D + 4) ? (h0 + 1) % 24 : h0);
      end
      btn_inc = 1'b0;
      repeat (D + 8) @(negedge clk);
      check_fields("bounce_done");
      go_run();

      // Simultaneous buttons.
      cur_hour = 5'd7; cur_min = 6'd8; cur_sec = 6'd9;
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b1); check_fields("simul_incdec");
      press(1'b1, 1'b1, 1'b0); check_fields("simul_modeinc");
      press(1'b0, 1'b0, 1'b1); check_fields("simul_dec");
      go_run();

      // Timeout: enter edit, then stay idle.
      cur_hour = 5'd3; cur_min = 6'd4; cur_sec = 6'd5;
      press(1'b1, 1'b0, 1'b0); check_fields("tmo_entry");
      repeat (126) @(negedge clk);
      check("tmo_still_editing", editing, 1);
      repeat (65) @(negedge clk);
      m_state = 0;
      check_fields("tmo_expired");
      check("tmo_no_load", exp_q.size(), 0);

      // Reset in SET_MIN discards the edit.
      cur_hour = 5'd19; cur_min = 6'd45; cur_sec = 6'd30;
      press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0); check_fields("rstmid_setmin");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      m_state = 0; m_h = 0; m_m = 0; m_s = 0;
      check("rstmid_load", load, 0);
      check_fields("rstmid");
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Blink in SET_SEC, then an inc forces the digits visible.
      cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
      press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0);
      apply(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      btn_mode = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 12) btn_mode = 1'b0;
         if (k == 42) begin
            apply(1'b0, 1'b1, 1'b0);
            btn_inc = 1'b1;
         end
         if (k == 54) btn_inc = 1'b0;
         if (k >= 8) begin
            if (k < 50) em = (((k - 8) / B) % 2 == 1) ? 8'h03 : 8'h00;
            else em = (((k - 50) / B) % 2 == 1) ? 8'h03 : 8'h00;
            check("blink_mask", blink_mask, em);
         end
      end
      repeat (D + 8) @(negedge clk);
      check_fields("blink_done");
      go_run();

      // Randomized press sequences, including out-of-range live values.
      for (int it = 0; it < 40; it++) begin
         cur_hour = 5'($urandom_range(0, 31));
         cur_min  = 6'($urandom_range(0, 63));
         cur_sec  = 6'($urandom_range(0, 63));
         r = $urandom_range(0, 9);
         if (r <= 3) press(1'b1, 1'b0, 1'b0);
         else if (r <= 5) press(1'b0, 1'b1, 1'b0);
         else if (r <= 7) press(1'b0, 1'b0, 1'b1);
         else if (r == 8) press(1'b0, 1'b1, 1'b1);
         else press(1'b1, 1'b0, 1'b1);
         check_fields("rand");
      end
      go_run();

      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
